// File: rtl/cpu_defs.sv
// Shared opcode, field and FSM definitions for the fetch front end.
// Used by instr_fetch and pc_unit.
package cpu_defs;

  localparam logic [3:0] OP_LOGIC = 4'b0000;
  localparam logic [3:0] OP_ARITH = 4'b0001;
  localparam logic [3:0] OP_ADDI  = 4'b1001;
  localparam logic [3:0] OP_SUBI  = 4'b1010;
  localparam logic [3:0] OP_SLTI  = 4'b1011;

  localparam int OP_HI  = 15;
  localparam int OP_LO  = 12;
  localparam int RS_HI  = 11;
  localparam int RS_LO  = 10;
  localparam int RT_HI  = 9;
  localparam int RT_LO  = 8;
  localparam int RD_HI  = 7;
  localparam int RD_LO  = 6;
  localparam int FN_HI  = 1;
  localparam int FN_LO  = 0;
  localparam int IMM_HI = 7;
  localparam int IMM_LO = 0;

  localparam logic [1:0] S_IDLE = 2'd0;
  localparam logic [1:0] S_REQ  = 2'd1;
  localparam logic [1:0] S_HOLD = 2'd2;

  function automatic logic isLegalOp(input logic [3:0] op);
    logic legal;
    legal = 1'b0;
    unique case (1'b1)
      (op == OP_LOGIC): legal = 1'b1;
      (op == OP_ARITH): legal = 1'b1;
      (op == OP_ADDI):  legal = 1'b1;
      (op == OP_SUBI):  legal = 1'b1;
      (op == OP_SLTI):  legal = 1'b1;
      default:          legal = 1'b0;
    endcase
    return legal;
  endfunction

endpackage

// File: rtl/pc_unit.sv
// Program counter with +1 increment and branch redirect.
// A redirect during an outstanding request is parked until the ack.
module pc_unit
  import cpu_defs::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              inReq,
  input  logic              ack,
  input  logic              branchTaken,
  input  logic [ADDR_W-1:0] branchTarget,
  output logic [ADDR_W-1:0] pc,
  output logic              kill
);

  logic [ADDR_W-1:0] pcQ;
  logic [ADDR_W-1:0] targetQ;
  logic              killQ;

  // PC stays frozen while a request is in flight so the address is stable
  always_ff @(posedge Clock) begin
    if (Reset) begin
      pcQ     <= RESET_PC;
      targetQ <= '0;
      killQ   <= 1'b0;
    end else if (branchTaken) begin
      if (inReq && !ack) begin
        killQ   <= 1'b1;
        targetQ <= branchTarget;
      end else begin
        pcQ   <= branchTarget;
        killQ <= 1'b0;
      end
    end else if (inReq && ack) begin
      killQ <= 1'b0;
      pcQ   <= killQ ? targetQ : pcQ + ADDR_W'(1);
    end
  end

  assign pc   = pcQ;
  assign kill = killQ;

endmodule

// File: rtl/instr_fetch.sv
// Instruction fetch: memory req/ack on one side, IR with
// valid/ready toward decode on the other.
module instr_fetch
  import cpu_defs::*;
#(
  parameter int                 ADDR_W   = 8,
  parameter logic [ADDR_W-1:0]  RESET_PC = '0,
  parameter int                 CNT_W    = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  output logic              imem_req,
  output logic [ADDR_W-1:0] imem_addr,
  input  logic              imem_ack,
  input  logic [15:0]       imem_rdata,
  output logic              if_valid,
  input  logic              if_ready,
  output logic [3:0]        OPCODE,
  output logic [1:0]        rs,
  output logic [1:0]        rt,
  output logic [1:0]        rd,
  output logic [1:0]        funct,
  output logic [7:0]        imm,
  output logic [ADDR_W-1:0] pc_out,
  output logic              illegal_op,
  input  logic              branch_taken,
  input  logic [ADDR_W-1:0] branch_target,
  output logic [CNT_W-1:0]  fetch_count
);

  logic [1:0]        state;
  logic [15:0]       ir;
  logic [ADDR_W-1:0] pcOutQ;
  logic [CNT_W-1:0]  fetchCount;
  logic [ADDR_W-1:0] pc;
  logic              kill;
  logic              inReq;

  assign inReq = (state == S_REQ);

  pc_unit #(
    .ADDR_W   (ADDR_W),
    .RESET_PC (RESET_PC)
  ) uPc (
    .Clock        (Clock),
    .Reset        (Reset),
    .inReq        (inReq),
    .ack          (imem_ack),
    .branchTaken  (branch_taken),
    .branchTarget (branch_target),
    .pc           (pc),
    .kill         (kill)
  );

  // Fetch FSM, instruction register and saturating accept counter
  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= S_IDLE;
      ir         <= '0;
      pcOutQ     <= '0;
      fetchCount <= '0;
    end else begin
      unique case (state)
        S_IDLE: state <= S_REQ;
        S_REQ: begin
          if (imem_ack && !branch_taken && !kill) begin
            ir     <= imem_rdata;
            pcOutQ <= pc;
            state  <= S_HOLD;
          end
        end
        S_HOLD: begin
          if (branch_taken) begin
            state <= S_REQ;
          end else if (if_ready) begin
            state <= S_REQ;
            if (fetchCount != '1) begin
              fetchCount <= fetchCount + CNT_W'(1);
            end
          end
        end
        default: state <= S_IDLE;
      endcase
    end
  end

  assign imem_req    = inReq;
  assign imem_addr   = pc;
  assign if_valid    = (state == S_HOLD);
  assign OPCODE      = ir[OP_HI:OP_LO];
  assign rs          = ir[RS_HI:RS_LO];
  assign rt          = ir[RT_HI:RT_LO];
  assign rd          = ir[RD_HI:RD_LO];
  assign funct       = ir[FN_HI:FN_LO];
  assign imm         = ir[IMM_HI:IMM_LO];
  assign pc_out      = pcOutQ;
  assign illegal_op  = if_valid && !isLegalOp(OPCODE);
  assign fetch_count = fetchCount;

endmodule
